serial_subtractor_ctrl: RTL and testbench

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 113 +++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter only needs to reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = a - b - Bin, Bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = a ^ b ^ Bin;
  assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor (LSB first, one bit per cycle) with valid/ready handshakes.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d_bit, b_bit;
  logic             last;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep them aside.
  logic a_msb, b_msb;
`endif

  full_subtractor u_fsub (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .Bin  (brw),
    .D    (d_bit),
    .Bout (b_bit)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      cnt       <= '0;
      brw       <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            brw      <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          diff <= {d_bit, diff[WIDTH-1:1]};
          brw  <= b_bit;
          cnt  <= cnt + CW'(1);
          if (last) begin
            bout      <= b_bit;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit here is the final result MSB.
            ovf       <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed + randomized bench for serial_subtractor_ctrl against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow when the true result is negative.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi,
                                output logic [W-1:0] md, output logic mbo, output logic mov);
    longint t;
    t   = longint'(ma) - longint'(mb) - longint'(mbi);
    md  = W'(t);
    mbo = (t < 0);
    mov = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
  endfunction

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obi,
                        input int hold, input bit noise);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           guard;
    model(oa, ob, obi, ed, eb, eo);
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    a = oa; b = ob; bin = obi; in_valid = 1'b1;
    step();
    chk("in_ready_in_run", in_ready, 0);
    if (!noise) in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (noise) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      step();
      if (i < W - 1) chk("out_valid_early", out_valid, 0);
      else           chk("out_valid_latency", out_valid, 1);
    end
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    chk("in_ready_in_done", in_ready, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", ovf, eo);
`endif
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_diff", diff, ed);
      chk("hold_bout", bout, eb);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    // Reset wins over in_valid on the same edge.
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("rst_prio_in_ready", in_ready, 1);

    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
    run_op(8'h3C, 8'hA5, 1'b1, 5, 1'b0);
    run_op(8'h9A, 8'h47, 1'b0, 2, 1'b1);

    // Abort mid-RUN.
    a = 8'hC3; b = 8'h12; bin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    run_op(8'h05, 8'h03, 1'b0, 1, 1'b0);

    for (int n = 0; n < 24; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
